// File: rtl/conv_layer_mc.sv
// conv_layer_mc: streaming multi-channel fixed-point convolution with loadable
// per-channel weights and bias, round-half-up, saturation and optional ReLU.
module conv_layer_mc #(
  parameter int NUM_CH = 3,
  parameter int TAPS   = 25,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40,
  localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int TAP_W = TAPS > 1 ? $clog2(TAPS) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     relu_en_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [DATA_W-1:0] in_data_i,
  input  logic                     wr_en_i,
  input  logic                     wr_bias_i,
  input  logic [CH_W-1:0]          wr_ch_i,
  input  logic [TAP_W-1:0]         wr_tap_i,
  input  logic signed [DATA_W-1:0] wr_data_i,
  output logic                     wr_err_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [NUM_CH*DATA_W-1:0] out_data_o,
  output logic [NUM_CH-1:0]        out_sat_o,
  output logic                     busy_o
);
  typedef enum logic [1:0] {IDLE, ACCUM, FINISH, OUT} state_e;
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] HALF  = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
  state_e                   state_q;
  logic [TAP_W-1:0]         tap_q;
  logic                     relu_q, wr_err_q;
  logic [NUM_CH*DATA_W-1:0] out_data_q, res_d;
  logic [NUM_CH-1:0]        out_sat_q, sat_d;
  logic                     fire, hs, go, last, wr_ok;
  always_comb begin
    fire  = state_q == ACCUM && in_valid_i;
    hs    = state_q == OUT && out_ready_i;
    go    = start_i && (state_q == IDLE || hs);
    last  = tap_q == TAP_W'(TAPS - 1);
    wr_ok = wr_en_i && state_q == IDLE && {1'b0, wr_ch_i} < (CH_W+1)'(NUM_CH)
            && (wr_bias_i || {1'b0, wr_tap_i} < (TAP_W+1)'(TAPS));
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [DATA_W-1:0]   w_q [TAPS];
    logic signed [DATA_W-1:0]   b_q, clip;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q, acc_d, sum, r;
    logic                       hit, ovf, unf;
    always_comb begin
      prod  = in_data_i * w_q[tap_q];
      acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      sum   = acc_q + ({{(ACC_W-DATA_W){b_q[DATA_W-1]}}, b_q} << FRAC_W) + HALF;
      r     = sum >>> FRAC_W;
      ovf   = r > MAX_V;
      unf   = r < MIN_V;
      clip  = ovf ? MAX_V[DATA_W-1:0] : unf ? MIN_V[DATA_W-1:0] : r[DATA_W-1:0];
      hit   = wr_ok && wr_ch_i == CH_W'(c);
    end
    assign res_d[c*DATA_W +: DATA_W] = relu_q && clip[DATA_W-1] ? '0 : clip;
    assign sat_d[c] = ovf || unf;
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        acc_q <= '0;
        b_q   <= '0;
        for (int t = 0; t < TAPS; t++) w_q[t] <= '0;
      end else begin
        if (go) acc_q <= '0;
        else if (fire) acc_q <= acc_d;
        if (hit && wr_bias_i) b_q <= wr_data_i;
        if (hit && !wr_bias_i) w_q[wr_tap_i] <= wr_data_i;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      tap_q      <= '0;
      relu_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= '0;
    end else begin
      wr_err_q <= wr_en_i && !wr_ok;
      if (go) begin
        state_q <= ACCUM;
        tap_q   <= '0;
        relu_q  <= relu_en_i;
      end else if (hs) state_q <= IDLE;
      else if (fire) begin
        tap_q <= last ? '0 : tap_q + 1'b1;
        if (last) state_q <= FINISH;
      end else if (state_q == FINISH) begin
        out_data_q <= res_d;
        out_sat_q  <= sat_d;
        state_q    <= OUT;
      end
    end
  end
  assign in_ready_o  = state_q == ACCUM;
  assign busy_o      = state_q != IDLE;
  assign out_valid_o = state_q == OUT;
  assign out_data_o  = out_data_q;
  assign out_sat_o   = out_sat_q;
  assign wr_err_o    = wr_err_q;
endmodule

// File: tb/tb_conv_layer_mc.sv
// tb_conv_layer_mc: directed bench for conv_layer_mc with hand-computed results.
module tb_conv_layer_mc;
  logic        clk_i = 0, reset_i = 1, start_i = 0, relu_en_i = 0;
  logic        in_valid_i = 0, in_ready_o, wr_en_i = 0, wr_bias_i = 0;
  logic signed [15:0] in_data_i = 0, wr_data_i = 0;
  logic [1:0]  wr_ch_i = 0;
  logic [4:0]  wr_tap_i = 0;
  logic        wr_err_o, out_valid_o, out_ready_i = 0, busy_o;
  logic [47:0] out_data_o, held;
  logic [2:0]  out_sat_o;
  int          passed = 0, total = 0, fails = 0;

  conv_layer_mc dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .relu_en_i(relu_en_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .wr_en_i(wr_en_i), .wr_bias_i(wr_bias_i), .wr_ch_i(wr_ch_i), .wr_tap_i(wr_tap_i),
    .wr_data_i(wr_data_i), .wr_err_o(wr_err_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_sat_o(out_sat_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [47:0] pk(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic bias, input int ch, input int tap, input int data);
    wr_en_i = 1; wr_bias_i = bias; wr_ch_i = 2'(ch); wr_tap_i = 5'(tap); wr_data_i = 16'(data);
    tick();
    wr_en_i = 0;
  endtask

  task automatic load(input int w0, input int w1, input int w2, input int b0, input int b1, input int b2);
    for (int t = 0; t < 25; t++) begin
      wr(0, 0, t, w0); wr(0, 1, t, w1); wr(0, 2, t, w2);
    end
    wr(1, 0, 0, b0); wr(1, 1, 0, b1); wr(1, 2, 0, b2);
  endtask

  task automatic go(input logic relu);
    start_i = 1; relu_en_i = relu;
    tick();
    start_i = 0;
  endtask

  task automatic feed(input int n, input int val, input logic gaps);
    int acc = 0, cyc = 0;
    while (acc < n && cyc < 2000) begin
      in_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data_i = 16'(val);
      if (in_valid_i && in_ready_o) acc++;
      tick();
      cyc++;
    end
    in_valid_i = 0;
    chk("feed_accepts", 64'(acc), 64'(n));
  endtask

  task automatic result(input string tag, input logic [47:0] d, input logic [2:0] s);
    chk({tag, "_finish_nvalid"}, 64'(out_valid_o), 64'(0));
    tick();
    chk({tag, "_valid"}, 64'(out_valid_o), 64'(1));
    chk({tag, "_data"}, 64'(out_data_o), 64'(d));
    chk({tag, "_sat"}, 64'(out_sat_o), 64'(s));
  endtask

  task automatic drain();
    out_ready_i = 1;
    tick();
    out_ready_i = 0;
    chk("drain_nvalid", 64'(out_valid_o), 64'(0));
    chk("drain_idle", 64'(busy_o), 64'(0));
  endtask

  initial begin
    tick(); tick();
    reset_i = 0;
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_in_ready", 64'(in_ready_o), 64'(0));
    chk("rst_out_valid", 64'(out_valid_o), 64'(0));
    chk("rst_out_data", 64'(out_data_o), 64'(0));
    chk("rst_out_sat", 64'(out_sat_o), 64'(0));
    chk("rst_wr_err", 64'(wr_err_o), 64'(0));

    load(256, -256, 128, 0, 0, 0);
    chk("legal_wr_err", 64'(wr_err_o), 64'(0));
    go(0);
    chk("accum_in_ready", 64'(in_ready_o), 64'(1));
    feed(25, 256, 0);
    result("basic", pk(6400, -6400, 3200), 3'b000);
    drain();

    wr(1, 1, 0, 128);
    go(1);
    feed(25, 256, 0);
    result("relu_bias", pk(6400, 0, 3200), 3'b000);
    drain();

    load(32767, 1, -32768, 0, 0, 0);
    go(0);
    feed(25, 128, 0);
    result("sat_round", pk(32767, 13, -32768), 3'b101);
    drain();

    go(0);
    feed(25, 128, 1);
    result("gappy", pk(32767, 13, -32768), 3'b101);
    held = out_data_o;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_data", 64'(out_data_o), 64'(held));
      chk("stall_valid", 64'(out_valid_o), 64'(1));
      chk("stall_in_ready", 64'(in_ready_o), 64'(0));
    end
    out_ready_i = 1; start_i = 1; relu_en_i = 1;
    tick();
    out_ready_i = 0; start_i = 0;
    chk("b2b_busy", 64'(busy_o), 64'(1));
    chk("b2b_in_ready", 64'(in_ready_o), 64'(1));
    chk("b2b_nvalid", 64'(out_valid_o), 64'(0));
    feed(25, 256, 0);
    result("b2b_relu_sat", pk(32767, 25, 0), 3'b101);
    drain();

    go(0);
    feed(5, 128, 0);
    wr_en_i = 1; wr_bias_i = 0; wr_ch_i = 1; wr_tap_i = 0; wr_data_i = 999;
    in_valid_i = 1; in_data_i = 128;
    tick();
    wr_en_i = 0; in_valid_i = 0;
    chk("ill_wr_err_pulse", 64'(wr_err_o), 64'(1));
    tick();
    chk("ill_wr_err_clear", 64'(wr_err_o), 64'(0));
    feed(19, 128, 0);
    result("ill_wr_window", pk(32767, 13, -32768), 3'b101);
    drain();
    go(0);
    feed(25, 128, 0);
    result("ill_wr_readback", pk(32767, 13, -32768), 3'b101);
    drain();

    wr(1, 0, 0, 256);
    go(0);
    feed(12, 128, 0);
    reset_i = 1;
    tick();
    reset_i = 0;
    chk("mid_rst_busy", 64'(busy_o), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready_o), 64'(0));
    chk("mid_rst_out_valid", 64'(out_valid_o), 64'(0));
    chk("mid_rst_out_data", 64'(out_data_o), 64'(0));
    go(0);
    feed(25, 128, 0);
    result("post_rst_cleared", pk(0, 0, 0), 3'b000);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
